truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Closed-loop stimulus/capture stage wrapped around a 3-input combinational logic gate.
- Drives the gate inputs in1, in2, in3 through all 8 rows (000 to 111), waits a settle dwell per row, then samples the gate output.
- Assembles an 8-bit truth-table word and compares it against an expected hex ID. For example, a gate named 0x86 must return truth = 8'h86.
- Sits directly upstream of the gate (feeds it) and downstream of it (consumes its output).

Parameters:
- DWELL_CYCLES, 4: clock cycles each row is held before its sample; legal range 1..255.
- EXPECTED, 8'h86: truth word that sets match.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; sampled in IDLE only.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- in1  output  1  gate input, MSB of row index.
- in2  output  1  gate input.
- in3  output  1  gate input, LSB of row index.
- out  input  1  gate output, sampled by this block.
- truth  output  8  captured word; bit[7-r] = out at row r = {in1,in2,in3}.
- match  output  1  truth == EXPECTED; valid from done onward.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, {in1,in2,in3}=000, busy=0, done=0, truth=8'h00, match=0, row=0, cnt=0.
- State IDLE:
  - Inputs held at 000.
  - start=1 at edge E0: go to DRIVE, row=0, cnt=0, busy=1, truth cleared to 0, match=0.
- State DRIVE:
  - {in1,in2,in3} = row (registered outputs).
  - cnt increments each cycle.
  - On the edge where cnt==DWELL_CYCLES-1, out is captured into truth[7-row] and cnt resets to 0.
  - If row<7: row increments, stay in DRIVE.
  - If row==7: go to DONE.
- State DONE (one cycle):
  - done=1, busy=0, match=(truth==EXPECTED), inputs return to 000.
  - Next cycle: IDLE.
- Latency: truth is complete and done is high in the cycle following edge E0+8*DWELL_CYCLES.
  - DWELL_CYCLES=1: row changes every cycle; done follows 8 cycles after start.
- Holding: truth and match hold after done until the next start is accepted.
- start while busy or during DONE: ignored, with no restart and no queuing.
  - start held high continuously: a new sweep begins in the IDLE cycle after DONE.
- Sampling: out is sampled only at the last dwell cycle of each row; earlier glitches are ignored.
- Counter: cnt is $clog2(DWELL_CYCLES+1) bits wide; row is 3 bits wide and does not wrap (terminates at 7).
- rst mid-sweep: returns to IDLE next edge with all reset values; a partial truth word is discarded and no done pulse is issued.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro: SWEEP_MAJORITY_EN.
- Defined:
  - Each row's bit is the 2-of-3 majority of out sampled on the last three dwell cycles (cnt = DWELL-3, DWELL-2, DWELL-1).
  - DWELL_CYCLES < 3 is a compile-time error (elaboration $error).
  - Latency is unchanged.
- Undefined: single sample on the last dwell cycle, as described in Behaviour.

Decomposition:
- Package sweep_pkg holds:
  - state enum (IDLE, DRIVE, DONE);
  - ROWS=8 and ROW_W=3;
  - function row_to_bit(r) = 7-r.
- Optional sub-module: sweep_majority3.
  - 3-bit shift of out samples plus a majority function.
  - Instantiated only under SWEEP_MAJORITY_EN.

Test Plan:
- Nominal sweep:
  - Stimulus: bench models gate 0x86 (rows 000, 101, 110 give 1); DWELL=4; start pulse at cycle 10.
  - Expect: in rows 000..111 each held 4 cycles; done at cycle 43; truth=8'h86; match=1.
- Mismatch:
  - Stimulus: gate model is a constant 0.
  - Expect: truth=8'h00, match=0, done pulses once.
- Reset mid-sweep:
  - Stimulus: assert rst at row 3.
  - Expect next cycle: busy=0, inputs 000, truth=0, no done. A fresh start then yields truth=8'h86.
- start during sweep:
  - Stimulus: pulse start at rows 2 and 6.
  - Expect: no restart; done timing unchanged.
- Edge dwell:
  - Stimulus: DWELL=1, start held high.
  - Expect: back-to-back sweeps, done every 10 cycles, truth=8'h86 each time.
- SWEEP_MAJORITY_EN:
  - Stimulus: DWELL=4; inject a single-cycle out glitch on the last dwell cycle of row 101.
  - Expect: truth=8'h86 with the macro defined; truth=8'h82 with it undefined.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Optional feature: SWEEP_MAJORITY_EN (see truth_table_sweeper.sv).
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned ROW_W = 3;

    // Row r of the truth table lands in bit 7-r, so row 000 is the MSB.
    function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] r);
        return ROW_W'(ROWS - 1) - r;
    endfunction

endpackage

// File: rtl/sweep_majority3.sv
// 2-of-3 majority filter over the gate output: two registered history
// samples plus the live sample form a 3-sample window. Used only when
// SWEEP_MAJORITY_EN is defined.
module sweep_majority3 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic shift_en_i,
    input  logic sample_i,
    output logic maj_o
);

    logic [1:0] hist_q, hist_d;
    logic [2:0] window;

    // Shift the newest sample in on every enabled cycle.
    always_comb begin
        hist_d = hist_q;
        if (shift_en_i) begin
            hist_d = {hist_q[0], sample_i};
        end
    end

    // History register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign window = {hist_q, sample_i};
    assign maj_o  = (window[2] & window[1]) | (window[2] & window[0]) | (window[1] & window[0]);

endmodule

// File: rtl/truth_table_sweeper.sv
// Closed-loop truth-table sweeper around a 3-input combinational gate.
// Drives rows 000..111, dwells DWELL_CYCLES per row, captures the gate
// output into an 8-bit truth word and compares it against EXPECTED.
// Macro SWEEP_MAJORITY_EN: per-row bit becomes the 2-of-3 majority of the
// last three dwell samples (requires DWELL_CYCLES >= 3).
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter logic [7:0]  EXPECTED     = 8'h86
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       out,
    output logic [7:0] truth,
    output logic       match
);

    localparam int unsigned      CNT_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_dwell_range
        $error("truth_table_sweeper: DWELL_CYCLES must be in 1..255");
    end

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] in_q, in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       truth_q, truth_d;
    logic             match_q, match_d;
    logic             row_bit;

`ifdef SWEEP_MAJORITY_EN
    if (DWELL_CYCLES < 3) begin : g_dwell_maj
        $error("truth_table_sweeper: SWEEP_MAJORITY_EN needs DWELL_CYCLES >= 3");
    end

    // The history shifts every DRIVE cycle, so at the capture edge it holds
    // the samples from cnt = DWELL-3 and DWELL-2, and the live one is DWELL-1.
    sweep_majority3 u_majority3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .shift_en_i (state_q == DRIVE),
        .sample_i   (out),
        .maj_o      (row_bit)
    );
`else
    assign row_bit = out;
`endif

    // Next-state and registered-output logic for the sweep sequence.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        in_d    = in_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        truth_d = truth_q;
        match_d = match_q;

        case (state_q)
            IDLE: begin
                in_d = '0;
                if (start) begin
                    state_d = DRIVE;
                    row_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    truth_d = '0;
                    match_d = 1'b0;
                end
            end

            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    truth_d[row_to_bit(row_q)] = row_bit;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        in_d    = '0;
                        match_d = (truth_d == EXPECTED);
                    end else begin
                        row_d = row_q + ROW_W'(1);
                        in_d  = row_d;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                in_d    = '0;
            end

            default: begin
                state_d = IDLE;
                in_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            in_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            truth_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            truth_q <= truth_d;
            match_q <= match_d;
        end
    end

    assign {in1, in2, in3} = in_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign truth = truth_q;
    assign match = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: gate models driven from
// truth tables, randomized sweeps checked against a cycle-indexed model.
module tb_truth_table_sweeper;

`ifdef SWEEP_MAJORITY_EN
    localparam bit          MAJ = 1'b1;
    localparam int unsigned D1  = 3;
`else
    localparam bit          MAJ = 1'b0;
    localparam int unsigned D1  = 1;
`endif
    localparam int unsigned D4   = 4;
    localparam logic [7:0]  EXP4 = 8'h86;
    localparam logic [7:0]  EXP1 = 8'h86;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start1;
    logic       busy4, done4, a4, b4, c4, out4, match4;
    logic       busy1, done1, a1, b1, c1, out1, match1;
    logic [7:0] truth4, truth1;
    logic [7:0] tbl4, tbl1;
    logic       glitch4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Gate model: row index idx = {in1,in2,in3} reads bit 7-idx of its table.
    function automatic logic gate(input logic [7:0] t, input int idx);
        return t[7 - idx];
    endfunction

    assign out4 = gate(tbl4, int'({a4, b4, c4})) ^ glitch4;
    assign out1 = gate(tbl1, int'({a1, b1, c1}));

    truth_table_sweeper #(.DWELL_CYCLES(D4), .EXPECTED(EXP4)) dut (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .in1(a4), .in2(b4), .in3(c4), .out(out4), .truth(truth4), .match(match4)
    );

    truth_table_sweeper #(.DWELL_CYCLES(D1), .EXPECTED(EXP1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .in1(a1), .in2(b1), .in3(c1), .out(out1), .truth(truth1), .match(match1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sweep on dut. grow >= 0 flips out on the last dwell cycle of that
    // row; early_mask rows get a flip on their first dwell cycle (always
    // ignored); mid_start pulses start during rows 2, 6 and in the done cycle.
    task automatic run_sweep(input logic [7:0] tbl, input int grow,
                             input logic [7:0] early_mask, input bit mid_start);
        logic [7:0] exp_t;
        int row, phase;
        exp_t = tbl;
        if (grow >= 0 && !MAJ) exp_t[7 - grow] = ~exp_t[7 - grow];
        tbl4 = tbl;
        @(posedge clk); #1 start4 = 1'b1;
        for (int j = 0; j <= int'(8 * D4) + 2; j++) begin
            @(posedge clk); #1;
            start4 = mid_start && (j == int'(2 * D4) + 1 || j == int'(6 * D4) + 1 || j == int'(8 * D4));
            row   = j / int'(D4);
            phase = j % int'(D4);
            glitch4 = (j < int'(8 * D4)) &&
                      ((row == grow && phase == int'(D4) - 1) || (early_mask[7 - row] && phase == 0));
            @(negedge clk);
            if (j < int'(8 * D4)) begin
                check_eq("row_inputs", 32'({a4, b4, c4}), 32'(row));
                check_eq("busy_drive", 32'(busy4), 32'd1);
                check_eq("done_drive", 32'(done4), 32'd0);
                if (j == 0) begin
                    check_eq("truth_cleared", 32'(truth4), 32'd0);
                    check_eq("match_cleared", 32'(match4), 32'd0);
                end
            end else begin
                check_eq("done_pulse", 32'(done4), (j == int'(8 * D4)) ? 32'd1 : 32'd0);
                check_eq("busy_end", 32'(busy4), 32'd0);
                check_eq("inputs_end", 32'({a4, b4, c4}), 32'd0);
                check_eq("truth", 32'(truth4), 32'(exp_t));
                check_eq("match", 32'(match4), 32'(exp_t == EXP4));
            end
        end
        glitch4 = 1'b0;
        start4  = 1'b0;
    endtask

    // Start a sweep, reset it during row rrow, then confirm a quiet IDLE.
    task automatic run_reset(input logic [7:0] tbl, input int rrow);
        tbl4 = tbl;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        repeat (rrow * int'(D4) + 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy4), 32'd0);
        check_eq("rst_inputs", 32'({a4, b4, c4}), 32'd0);
        check_eq("rst_truth", 32'(truth4), 32'd0);
        check_eq("rst_done", 32'(done4), 32'd0);
        check_eq("rst_match", 32'(match4), 32'd0);
        for (int k = 0; k < int'(8 * D4); k++) begin
            @(negedge clk);
            check_eq("rst_no_done", 32'(done4), 32'd0);
            check_eq("rst_idle", 32'(busy4), 32'd0);
        end
    endtask

    // start held high on dut1: back-to-back sweeps every 8*D1+2 cycles.
    task automatic run_back_to_back();
        int p;
        p = int'(8 * D1) + 2;
        tbl1 = EXP1;
        @(posedge clk); #1 start1 = 1'b1;
        for (int j = 0; j < 3 * p; j++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("b2b_done", 32'(done1), (j % p == int'(8 * D1)) ? 32'd1 : 32'd0);
            check_eq("b2b_busy", 32'(busy1), (j % p < int'(8 * D1)) ? 32'd1 : 32'd0);
            if (j % p == int'(8 * D1)) begin
                check_eq("b2b_truth", 32'(truth1), 32'(EXP1));
                check_eq("b2b_match", 32'(match1), 32'd1);
            end
        end
        #1 start1 = 1'b0;
        repeat (p + 2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; glitch4 = 1'b0;
        tbl4 = 8'h86; tbl1 = 8'h86;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", 32'(busy4), 32'd0);
        check_eq("reset_done", 32'(done4), 32'd0);
        check_eq("reset_inputs", 32'({a4, b4, c4}), 32'd0);
        check_eq("reset_truth", 32'(truth4), 32'd0);
        check_eq("reset_match", 32'(match4), 32'd0);
        check_eq("reset_busy1", 32'(busy1), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        run_sweep(8'h86, -1, 8'h00, 1'b0);
        run_sweep(8'h00, -1, 8'h00, 1'b0);
        run_sweep(8'h86, 5, 8'h00, 1'b0);
        run_sweep(8'h86, -1, 8'hff, 1'b1);
        run_reset(8'h86, 3);
        run_sweep(8'h86, -1, 8'h00, 1'b0);
        run_back_to_back();

        for (int n = 0; n < 10; n++) begin
            run_sweep(8'($urandom), int'($urandom_range(0, 8)) - 1,
                      8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
